// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, state type and pointer helper for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_W     = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the arbiter.
interface rr_mux_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic [IDX_W-1:0]   out_src;
  logic               out_ready;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt,
  output logic             any
);

  // Scan farthest-first so the nearest pending request to ptr is the last write.
  always_comb begin
    int idx;
    gnt = '0;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx[IDX_W-1:0]]) gnt = idx[IDX_W-1:0];
    end
    any = |req;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 data mux into a single valid/ready output register.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int W     = DEFAULT_W
) (
  input logic          clk,
  input logic          rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);

  state_e                 state_q, state_d;
  logic                   load;
  logic [IDX_W-1:0]       ptr_q, gnt, src_q;
  logic                   any;
  logic [W-1:0]           data_q, sel_data;
  logic [N_REQ-1:0][W-1:0] words;

  assign words = bus.req_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .any (any)
  );

  assign sel_data = words[gnt];

  // The register accepts a new word when empty or when its current word leaves this cycle.
  always_comb begin
    state_d       = state_q;
    load          = (state_q == EMPTY) || bus.out_ready;
    bus.req_ready = '0;
    if (load) begin
      state_d = any ? FULL : EMPTY;
      if (any) bus.req_ready[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load && any) begin
        data_q <= sel_data;
        src_q  <= gnt;
        ptr_q  <= IDX_W'(rr_next(int'(gnt), N_REQ));
      end
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed vector bench for rr_mux_arbiter: table of per-cycle vectors plus corner sequences.
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N_REQ(4), .W(8)) bus ();

  rr_mux_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        ordy;
    logic        chk_rdy;
    logic [3:0]  rdy;
    logic        v;
    logic [7:0]  d;
    logic [1:0]  s;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // One cycle: drive, check combinational ready, clock, check registered outputs.
  task automatic apply(input vec_t v, input string tag);
    rst           = v.rst;
    bus.req_valid = v.rv;
    bus.req_data  = v.rd;
    bus.out_ready = v.ordy;
    #1;
    if (v.chk_rdy) chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v.v));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(v.d));
    chk({tag, ".out_src"},   32'(bus.out_src),   32'(v.s));
  endtask

  localparam logic [31:0] ALL4 = 32'h13121110;

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    //            rst  rv     rd            ordy chk rdy    v  d      s
    tbl[0]  = '{1'b1, 4'h0, 32'h0,        1'b0, 1, 4'h0, 0, 8'h00, 2'd0};
    tbl[1]  = '{1'b0, 4'h4, 32'h00330000, 1'b1, 1, 4'h4, 1, 8'h33, 2'd2};
    tbl[2]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1, 4'h0, 0, 8'h33, 2'd2};
    tbl[3]  = '{1'b0, 4'h0, 32'h0,        1'b0, 1, 4'h0, 0, 8'h33, 2'd2};
    tbl[4]  = '{1'b1, 4'h0, 32'h0,        1'b1, 0, 4'h0, 0, 8'h00, 2'd0};
    for (int i = 0; i < 8; i++)
      tbl[5+i] = '{1'b0, 4'hF, ALL4, 1'b1, 1, 4'(1 << (i % 4)), 1,
                   8'(8'h10 + (i % 4)), 2'(i % 4)};
    tbl[13] = '{1'b0, 4'h0, 32'h0,        1'b1, 1, 4'h0, 0, 8'h13, 2'd3};
    tbl[14] = '{1'b0, 4'h4, 32'h00220000, 1'b1, 1, 4'h4, 1, 8'h22, 2'd2};
    tbl[15] = '{1'b0, 4'h5, 32'h00A200A0, 1'b1, 1, 4'h1, 1, 8'hA0, 2'd0};
    tbl[16] = '{1'b0, 4'h5, 32'h00A200A0, 1'b1, 1, 4'h4, 1, 8'hA2, 2'd2};
    tbl[17] = '{1'b0, 4'h5, 32'h00A200A0, 1'b1, 1, 4'h1, 1, 8'hA0, 2'd0};

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: hold FULL src=1 while all four request, then release.
    apply('{1'b1, 4'h0, 32'h0,        1'b0, 0, 4'h0, 0, 8'h00, 2'd0}, "bp_rst");
    apply('{1'b0, 4'h2, 32'h0000B100, 1'b1, 1, 4'h2, 1, 8'hB1, 2'd1}, "bp_fill");
    for (int i = 0; i < 3; i++)
      apply('{1'b0, 4'hF, 32'hC3C2C1C0, 1'b0, 1, 4'h0, 1, 8'hB1, 2'd1},
            $sformatf("bp_hold%0d", i));
    apply('{1'b0, 4'hF, 32'hC3C2C1C0, 1'b1, 1, 4'h4, 1, 8'hC2, 2'd2}, "bp_release");

    // Drop before grant: requester 1 pulses while stalled, then vanishes.
    apply('{1'b0, 4'h2, 32'h0000D100, 1'b0, 1, 4'h0, 1, 8'hC2, 2'd2}, "drop_pulse");
    apply('{1'b0, 4'h0, 32'h0,        1'b1, 1, 4'h0, 0, 8'hC2, 2'd2}, "drop_gone");
    apply('{1'b0, 4'h0, 32'h0000D100, 1'b1, 1, 4'h0, 0, 8'hC2, 2'd2}, "drop_idle");

    // Reset mid-stream with 5A held, then the next grant must start from requester 0.
    apply('{1'b0, 4'h4, 32'h005A0000, 1'b1, 1, 4'h4, 1, 8'h5A, 2'd2}, "mid_fill");
    apply('{1'b1, 4'h0, 32'h0,        1'b0, 0, 4'h0, 0, 8'h00, 2'd0}, "mid_rst");
    apply('{1'b0, 4'h0, 32'h0,        1'b0, 1, 4'h0, 0, 8'h00, 2'd0}, "mid_quiet");
    apply('{1'b0, 4'hF, ALL4,         1'b1, 1, 4'h1, 1, 8'h10, 2'd0}, "mid_restart");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one N-to-1 data mux between N valid/ready requesters. Each cycle it picks one pending requester, drives the mux select and captures the selected word into a single output register. Downstream logic consumes that register through a valid/ready handshake. The block sits between several producer blocks and a single shared consumer. It is the sequencing and ownership layer for the mux datapath.

Parameters:
N_REQ, 4, number of requesters (>= 2)
W, 8, data width per requester
IDX_W, $clog2(N_REQ), width of requester index (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester valid
req_data  input  N_REQ*W  flattened data, requester i at bits [i*W +: W]
req_ready  output  N_REQ  per-requester accept, one-hot or zero
out_valid  output  1  output register holds a word
out_data  output  W  captured word
out_src  output  IDX_W  index of requester that supplied out_data
out_ready  input  1  downstream accept

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0. Reset overrides any handshake in the same cycle.
- FSM on the output register:
  - EMPTY when out_valid=0.
  - FULL when out_valid=1.
- load = !out_valid || out_ready. Capture is allowed in EMPTY, or in FULL when the current word is consumed this cycle.
- Grant selection (combinational): gnt = first i with req_valid[i]=1, scanning ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1. any_req = |req_valid.
- req_ready[i] = load && any_req && (gnt == i). At most one bit is high. req_ready depends combinationally on out_ready and req_valid; it has no dependency on req_data.
- A transfer on requester i occurs when req_valid[i] && req_ready[i].
- At the clock edge when load=1:
  - If any_req: out_valid<=1, out_data<=req_data[gnt], out_src<=gnt, ptr<=(gnt+1) mod N_REQ, with wrap from N_REQ-1 to 0.
  - Else: out_valid<=0, ptr unchanged, out_data/out_src hold their last values.
- At the clock edge when load=0 (FULL and out_ready=0): all state holds. out_data and out_src stay stable while out_valid=1 and out_ready=0.
- Latency: one cycle from a requester transfer to out_valid.
- Throughput: one word per cycle when out_ready is held high. A FULL register consumed and refilled in the same cycle gives back-to-back words.
- Fairness: a requester that keeps req_valid high is granted within N_REQ transfers.
- A requester may drop req_valid without being granted. No grant is remembered, and an ungranted request has no effect.
- out_ready while out_valid=0 is legal and ignored.
- The mux select is gnt. The data path is a pure N_REQ-to-1 mux; the only storage is the output register.

Decomposition:
- Package rr_mux_arbiter_pkg holds:
  - default constants (DEFAULT_N_REQ=4, DEFAULT_W=8);
  - a function rr_next(ptr, n) returning (ptr+1) mod n.
- One natural sub-module, rr_pick: purely combinational rotating-priority picker.
  - Inputs: req[N_REQ], ptr[IDX_W].
  - Outputs: gnt[IDX_W], any.
  - Reused by later arbiters.
- The data selection instantiates the team's existing 2:1 mux cell as a log2 tree, or a behavioural N-way select.

Test Plan:
- Reset mid-stream: out_valid=1, out_data=8'h5A, rst pulsed 1 cycle -> next cycle out_valid=0, out_data=0, out_src=0, no req_ready high; the next grant starts from requester 0.
- Single requester: only req_valid[2]=1 with data 8'h33, out_ready=1 -> req_ready=4'b0100 in cycle 0; cycle 1 out_valid=1, out_data=8'h33, out_src=2.
- All four valid, out_ready=1 for 8 cycles, data = 8'h10+i -> out_src sequence 0,1,2,3,0,1,2,3, one word per cycle, out_data matches.
- Backpressure: register FULL with src=1, out_ready=0 for 3 cycles while req_valid=4'b1111 -> req_ready=0, out_data and out_src stable. When out_ready rises, the same cycle grants requester 2 and the next cycle shows src=2.
- Wrap and skip: ptr=3, req_valid=4'b0101 -> grant 0, then ptr=1 -> grant 2; requester 3 never gets req_ready.
- Drop before grant: req_valid[1] pulsed while FULL and out_ready=0, then removed -> no transfer from 1, out_src never equals 1.
